sc_result_capture_fifo: RTL

- Reads the result side of the micro-datapath: the data out bus and the four active-low ALU flags.
- Captures {data, flags} into an 8-deep show-ahead FIFO whenever the state machine asserts an active-low capture strobe.
- Results can be drained by a downstream consumer (display or debug logic) through a valid/read handshake.
- Sits beside uDATAPATH in the system block, on the opposite end of the datapath output interface from the producer.

---
 rtl/sc_result_capture_fifo_if.sv | 60 ++++++
 rtl/sc_result_capture_fifo.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sc_result_capture_fifo_if.sv
// Result-capture bus: the producer-side strobe, the datapath word and its flags,
// the consumer read handshake and the FIFO status outputs. clear_InHigh is carried here too.
// The slave modport is the FIFO. The master modport is the state machine plus
// the downstream consumer.
interface sc_result_capture_fifo_if #(
    parameter int DATAWIDTH_BUS       = 16,
    parameter int DATAWIDTH_FIFO_ADDR = 3
);
    // Producer side: capture strobe, datapath word, active-low ALU flags
    logic                           SC_RESULTCAPTURE_clear_InHigh;
    logic                           SC_RESULTCAPTURE_capture_InLow;
    logic [DATAWIDTH_BUS-1:0]       SC_RESULTCAPTURE_data_InBUS;
    logic                           SC_RESULTCAPTURE_overflow_InLow;
    logic                           SC_RESULTCAPTURE_carry_InLow;
    logic                           SC_RESULTCAPTURE_negative_InLow;
    logic                           SC_RESULTCAPTURE_zero_InLow;

    // Consumer side: read handshake, head entry and status
    logic                           SC_RESULTCAPTURE_read_InHigh;
    logic [DATAWIDTH_BUS-1:0]       SC_RESULTCAPTURE_data_OutBUS;
    logic [3:0]                     SC_RESULTCAPTURE_flags_OutBUS;
    logic                           SC_RESULTCAPTURE_valid_OutHigh;
    logic                           SC_RESULTCAPTURE_full_OutHigh;
    logic [DATAWIDTH_FIFO_ADDR:0]   SC_RESULTCAPTURE_count_OutBUS;
    logic                           SC_RESULTCAPTURE_dropped_OutHigh;

    modport master (
        output SC_RESULTCAPTURE_clear_InHigh,
        output SC_RESULTCAPTURE_capture_InLow,
        output SC_RESULTCAPTURE_data_InBUS,
        output SC_RESULTCAPTURE_overflow_InLow,
        output SC_RESULTCAPTURE_carry_InLow,
        output SC_RESULTCAPTURE_negative_InLow,
        output SC_RESULTCAPTURE_zero_InLow,
        output SC_RESULTCAPTURE_read_InHigh,
        input  SC_RESULTCAPTURE_data_OutBUS,
        input  SC_RESULTCAPTURE_flags_OutBUS,
        input  SC_RESULTCAPTURE_valid_OutHigh,
        input  SC_RESULTCAPTURE_full_OutHigh,
        input  SC_RESULTCAPTURE_count_OutBUS,
        input  SC_RESULTCAPTURE_dropped_OutHigh
    );

    modport slave (
        input  SC_RESULTCAPTURE_clear_InHigh,
        input  SC_RESULTCAPTURE_capture_InLow,
        input  SC_RESULTCAPTURE_data_InBUS,
        input  SC_RESULTCAPTURE_overflow_InLow,
        input  SC_RESULTCAPTURE_carry_InLow,
        input  SC_RESULTCAPTURE_negative_InLow,
        input  SC_RESULTCAPTURE_zero_InLow,
        input  SC_RESULTCAPTURE_read_InHigh,
        output SC_RESULTCAPTURE_data_OutBUS,
        output SC_RESULTCAPTURE_flags_OutBUS,
        output SC_RESULTCAPTURE_valid_OutHigh,
        output SC_RESULTCAPTURE_full_OutHigh,
        output SC_RESULTCAPTURE_count_OutBUS,
        output SC_RESULTCAPTURE_dropped_OutHigh
    );
endinterface

// File: rtl/sc_result_capture_fifo.sv
// Result capture FIFO: stores {datapath word, active-high ALU flags} on each
// active-low capture strobe into a show-ahead FIFO. The FIFO is drained through
// a valid/read handshake. A capture that arrives while the FIFO is full is lost.
// Each lost capture is remembered in a sticky dropped flag.
module sc_result_capture_fifo #(
    parameter int DATAWIDTH_BUS       = 16,
    parameter int FIFO_DEPTH          = 8,
    parameter int DATAWIDTH_FIFO_ADDR = 3
) (
    input  logic                      SC_RESULTCAPTURE_CLOCK_50,
    input  logic                      SC_RESULTCAPTURE_RESET_InHigh,
    sc_result_capture_fifo_if.slave   resultBus
);

    localparam int ENTRY_WIDTH = DATAWIDTH_BUS + 4;

    localparam logic [DATAWIDTH_FIFO_ADDR-1:0] PTR_ONE    = DATAWIDTH_FIFO_ADDR'(1);
    localparam logic [DATAWIDTH_FIFO_ADDR:0]   COUNT_ONE  = (DATAWIDTH_FIFO_ADDR + 1)'(1);
    localparam logic [DATAWIDTH_FIFO_ADDR:0]   FULL_COUNT = (DATAWIDTH_FIFO_ADDR + 1)'(FIFO_DEPTH);

    // One stored entry: datapath word followed by the flags, already active-high
    typedef struct packed {
        logic [DATAWIDTH_BUS-1:0] data;
        logic                     overflow;
        logic                     carry;
        logic                     negative;
        logic                     zero;
    } entry_t;

    entry_t                          storage [FIFO_DEPTH];
    logic [DATAWIDTH_FIFO_ADDR-1:0]  wrPtr;
    logic [DATAWIDTH_FIFO_ADDR-1:0]  rdPtr;
    logic [DATAWIDTH_FIFO_ADDR:0]    count;
    logic                            dropped;

    logic                            isValid;
    logic                            isFull;
    logic                            captureReq;
    logic                            popEn;
    logic                            pushEn;
    logic                            dropEvent;
    entry_t                          newEntry;
    entry_t                          headEntry;

    // Status is a function of the registered occupancy only
    assign isValid    = (count != '0);
    assign isFull     = (count == FULL_COUNT);

    // Handshake decode. A read with nothing stored is ignored.
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign captureReq = ~resultBus.SC_RESULTCAPTURE_capture_InLow;
    assign popEn      = isValid & resultBus.SC_RESULTCAPTURE_read_InHigh;
    assign pushEn     = captureReq & (~isFull | popEn);
    assign dropEvent  = captureReq & isFull & ~popEn;

    // Flags are turned active-high at write time so consumers never see the polarity
    assign newEntry.data     = resultBus.SC_RESULTCAPTURE_data_InBUS;
    assign newEntry.overflow = ~resultBus.SC_RESULTCAPTURE_overflow_InLow;
    assign newEntry.carry    = ~resultBus.SC_RESULTCAPTURE_carry_InLow;
    assign newEntry.negative = ~resultBus.SC_RESULTCAPTURE_negative_InLow;
    assign newEntry.zero     = ~resultBus.SC_RESULTCAPTURE_zero_InLow;

    // Storage write on an accepted push; a flush discards the capture
    // NOTE: the storage array has no reset. Its contents are don't-care because
    // pointers and count are reset, and leaving it unreset keeps it mappable to RAM.
    always_ff @(posedge SC_RESULTCAPTURE_CLOCK_50) begin
        if (pushEn && !resultBus.SC_RESULTCAPTURE_clear_InHigh) begin
            storage[wrPtr] <= newEntry;
        end
    end

    // Pointer, occupancy and sticky-drop state; the flush wins over push and pop
    // NOTE: all state here uses non-blocking assignments. That way every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge SC_RESULTCAPTURE_CLOCK_50 or posedge SC_RESULTCAPTURE_RESET_InHigh) begin
        if (SC_RESULTCAPTURE_RESET_InHigh) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            dropped <= 1'b0;
        end else if (resultBus.SC_RESULTCAPTURE_clear_InHigh) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            dropped <= 1'b0;
        end else begin
            if (pushEn) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (popEn) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            if (pushEn && !popEn) begin
                count <= count + COUNT_ONE;
            end else if (popEn && !pushEn) begin
                count <= count - COUNT_ONE;
            end
            if (dropEvent) begin
                dropped <= 1'b1;
            end
        end
    end

    // Show-ahead head selection. Outputs are forced to zero while the FIFO is empty.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        headEntry = '0;
        if (isValid) begin
            headEntry = storage[rdPtr];
        end
    end

    assign resultBus.SC_RESULTCAPTURE_data_OutBUS     = headEntry.data;
    assign resultBus.SC_RESULTCAPTURE_flags_OutBUS    = {headEntry.overflow, headEntry.carry,
                                                         headEntry.negative, headEntry.zero};
    assign resultBus.SC_RESULTCAPTURE_valid_OutHigh   = isValid;
    assign resultBus.SC_RESULTCAPTURE_full_OutHigh    = isFull;
    assign resultBus.SC_RESULTCAPTURE_count_OutBUS    = count;
    assign resultBus.SC_RESULTCAPTURE_dropped_OutHigh = dropped;

endmodule
